// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - debouncer with rise/fall/long-press pulse outputs
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_sync_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } state_t;

    state_t        state_q;
    logic [DW-1:0] cnt_q;
    logic [LW-1:0] lp_q;
    logic          long_done_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic          long_q;

    logic level_high;
    logic long_hit;
    logic fall_commit;

    always_comb begin
        level_high  = (state_q == S_HIGH) || (state_q == S_FALL_WAIT);
        long_hit    = level_high && (lp_q == LP_LAST) && !long_done_q;
        fall_commit = (state_q == S_FALL_WAIT) && !in_sync_i && (cnt_q == DB_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_LOW;
            cnt_q       <= '0;
            lp_q        <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // Long press saturates at its terminal count; a coincident fall commit wins.
            long_q <= long_hit && !fall_commit;
            if (level_high && (lp_q != LP_LAST)) begin
                lp_q <= lp_q + 1'b1;
            end
            if (long_hit) begin
                long_done_q <= 1'b1;
            end

            case (state_q)
                S_LOW: begin
                    if (in_sync_i) begin
                        state_q <= S_RISE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_RISE_WAIT: begin
                    if (!in_sync_i) begin
                        state_q <= S_LOW;
                    end else if (cnt_q == DB_LAST) begin
                        state_q     <= S_HIGH;
                        level_q     <= 1'b1;
                        rise_q      <= 1'b1;
                        lp_q        <= '0;
                        long_done_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!in_sync_i) begin
                        state_q <= S_FALL_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_FALL_WAIT: begin
                    // Returning to S_HIGH keeps the long-press count running.
                    if (in_sync_i) begin
                        state_q <= S_HIGH;
                    end else if (fall_commit) begin
                        state_q <= S_LOW;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_LOW;
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign long_o  = long_q;

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - scoreboard bench for debounce_edge
module tb_debounce_edge;

    localparam int DB = 4;
    localparam int LP = 20;
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;
    localparam int K_LONG = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic in_sync_i = 1'b0;
    logic level_o, rise_o, fall_o, long_o;

    typedef struct {
        int kind;
        int edge_n;
    } ev_t;

    ev_t exp_q[$];
    int  edge_n  = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    debounce_edge #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .in_sync_i(in_sync_i),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .long_o   (long_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int at_edge);
        ev_t ev;
        ev.kind   = kind;
        ev.edge_n = at_edge;
        exp_q.push_back(ev);
    endtask

    task automatic observe(input int kind, input string nm);
        ev_t ev;
        if (exp_q.size() == 0) begin
            check_eq({"spurious_", nm}, edge_n, -1);
        end else begin
            ev = exp_q.pop_front();
            check_eq({nm, "_kind"}, kind, ev.kind);
            check_eq({nm, "_edge"}, edge_n, ev.edge_n);
        end
    endtask

    // Drive one input value, clock one edge, then sample outputs 1 time unit later.
    task automatic tick(input logic v);
        in_sync_i = v;
        @(posedge clk_i);
        edge_n++;
        #1;
        if (rise_o) observe(K_RISE, "rise");
        if (fall_o) observe(K_FALL, "fall");
        if (long_o) observe(K_LONG, "long");
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    int s;
    int r;

    initial begin
        // Reset held with input high: every output stays low.
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check_eq("rst_outputs", int'({level_o, rise_o, fall_o, long_o}), 0);
        end
        rst_i = 1'b0;
        s = edge_n + 1;
        expect_ev(K_RISE, s + DB);
        hold(1'b1, DB);
        check_eq("rst_rel_level_early", int'(level_o), 0);
        tick(1'b1);
        check_eq("rst_rel_level", int'(level_o), 1);
        rst_i = 1'b1;
        tick(1'b1);
        check_eq("rst_high_outputs", int'({level_o, rise_o, fall_o, long_o}), 0);
        rst_i = 1'b0;
        hold(1'b0, 3);
        check_drained("reset");

        // Clean press, long press with a glitch, then release.
        s = edge_n + 1;
        r = s + DB;
        expect_ev(K_RISE, r);
        hold(1'b1, DB + 1);
        check_eq("press_level", int'(level_o), 1);
        expect_ev(K_LONG, r + LP);
        hold(1'b1, 9);
        tick(1'b0);
        check_eq("glitch_level", int'(level_o), 1);
        hold(1'b1, 30);
        check_eq("long_hold_level", int'(level_o), 1);
        check_drained("long");
        s = edge_n + 1;
        expect_ev(K_FALL, s + DB);
        hold(1'b0, DB);
        check_eq("release_level_early", int'(level_o), 1);
        tick(1'b0);
        check_eq("release_level", int'(level_o), 0);
        hold(1'b0, 3);
        check_drained("release");

        // Bounce: three highs then a low, five times.
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 3);
            tick(1'b0);
        end
        check_eq("bounce_level", int'(level_o), 0);
        hold(1'b0, 2);
        check_drained("bounce");

        // Fall commit landing on the long-press terminal edge.
        s = edge_n + 1;
        r = s + DB;
        expect_ev(K_RISE, r);
        hold(1'b1, DB + 1);
        hold(1'b1, LP - DB - 1);
        expect_ev(K_FALL, r + LP);
        hold(1'b0, DB);
        tick(1'b0);
        check_eq("coinc_edge", edge_n, r + LP);
        check_eq("coinc_fall", int'(fall_o), 1);
        check_eq("coinc_long", int'(long_o), 0);
        hold(1'b0, 25);
        check_eq("coinc_level", int'(level_o), 0);
        check_drained("coinc");

        // Reset while mid-count in the rise wait; the count restarts afterwards.
        hold(1'b1, 3);
        rst_i = 1'b1;
        tick(1'b1);
        check_eq("midrst_outputs", int'({level_o, rise_o, fall_o, long_o}), 0);
        rst_i = 1'b0;
        s = edge_n + 1;
        expect_ev(K_RISE, s + DB);
        hold(1'b1, DB);
        check_eq("midrst_level_early", int'(level_o), 0);
        tick(1'b1);
        check_eq("midrst_level", int'(level_o), 1);
        hold(1'b1, 2);
        check_drained("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
